stdout_uart: RTL and testbench
==============================

STDOUT_UART -- requirements
Module: stdout_uart

Interface
REQ-001 SHALL have parameter DIV, default 868, meaning clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter DEPTH, default 8, meaning word-FIFO depth (power of two, at least 4).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port stdout_val_i, input, 1 bit: upstream word valid.
REQ-006 SHALL have port stdout_data_i, input, 16 bits: upstream word.
REQ-007 SHALL have port stdout_rdy_o, output, 1 bit: FIFO can accept a word.
REQ-008 SHALL have port stdout_flush_i, input, 1 bit: drain immediately; low means batch mode.
REQ-009 SHALL have port uart_tx_o, output, 1 bit: serial line, idle high.
REQ-010 SHALL have port busy_o, output, 1 bit: FIFO non-empty or formatter not IDLE.

Function
REQ-011 SHALL accept a word on a cycle where stdout_val_i && stdout_rdy_o, and push it into the FIFO.
REQ-012 SHALL drive stdout_rdy_o = (count < DEPTH), from registered count only; on a full FIFO, a same-cycle pop SHALL NOT enable a push.
REQ-013 SHALL use formatter states IDLE, LOAD, HEX, TERM.
- IDLE->LOAD when FIFO non-empty and (stdout_flush_i or count >= DEPTH/2).
- LOAD pops one word: 1 cycle.
- HEX emits 4 characters, MSB nibble first.
- TERM emits terminator characters, then returns to IDLE.
REQ-014 SHALL encode each nibble as uppercase ASCII: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-015 SHALL hand each character to the serialiser only when the serialiser is idle, with no gap cycle between consecutive characters of one word.
REQ-016 SHALL frame each character 8N1: start bit 0, data LSB first, stop bit 1; each bit held exactly DIV cycles, so one frame is 10*DIV cycles.
REQ-017 SHALL, with IDLE formatter, empty FIFO and stdout_flush_i=1, drive the start bit on uart_tx_o beginning 3 cycles after the accept edge (accept N, pop N+1, load N+2, line low from N+3).
REQ-018 SHALL always complete a word already in LOAD/HEX/TERM, regardless of stdout_flush_i falling.
REQ-019 SHALL, when stdout_flush_i rises with 1..DEPTH/2-1 words held, start draining within 1 cycle.
REQ-020 SHALL transmit words in acceptance order, with none dropped or duplicated.
REQ-021 SHALL handle count wrap-around using log2(DEPTH)+1-bit pointers, with full/empty from the MSB comparison.

Reset
REQ-022 SHALL, on a cycle with rst_i high, set the following at the next edge: FIFO empty, formatter IDLE, serialiser idle, uart_tx_o=1, stdout_rdy_o=1, busy_o=0.
REQ-023 SHALL, on reset mid-frame, truncate the character, discard all buffered words, and emit nothing further until new input arrives.

Configuration
REQ-024 SHALL use macro STDOUT_UART_CRLF_EN.
- Defined: TERM emits CR 0x0D then LF 0x0A, 6 characters per word.
- Undefined: TERM emits LF 0x0A only, 5 characters per word.

Structure
REQ-025 SHALL place the ASCII constants (CR, LF, digit bases), the formatter state enum and the nibble-to-ASCII function in shared package toy_pkg.
REQ-026 SHALL contain exactly one sub-module, uart_tx_core.
- uart_tx_core holds the baud counter, bit index and shift register.
- uart_tx_core interface: char_val/char_rdy/char_data[7:0], tx_o.

Verification
REQ-027 DIV=4, macro on, flush=1; push 0x1A2F -> frames 0x31,0x41,0x32,0x46,0x0D,0x0A; 40 cycles each; line low 3 cycles after accept; busy_o low after the last stop bit.
REQ-028 DEPTH=8, flush=0; push 3 words -> uart_tx_o stays high; push a 4th -> the first start bit follows; all 4 words are sent in order.
REQ-029 flush=1, DIV=4; push 12 words back-to-back -> stdout_rdy_o low while count==8; all 12 words are received intact and in order.
REQ-030 Reset pulse mid-data-bit of the 2nd character -> uart_tx_o=1 next cycle, stdout_rdy_o=1, busy_o=0; no further frames.
REQ-031 Macro off; push 0x0000 then 0xFFFF -> "0000"LF"FFFF"LF, 10 frames total.

Source files
------------

// File: rtl/toy_pkg.sv
// Shared constants, formatter state type and nibble encoder for stdout_uart.
// STDOUT_UART_CRLF_EN selects a CR+LF terminator instead of LF alone.
package toy_pkg;

    localparam logic [7:0] ASCII_CR         = 8'h0D;
    localparam logic [7:0] ASCII_LF         = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_BASE = 8'h41;

`ifdef STDOUT_UART_CRLF_EN
    localparam int TERM_LEN = 2;
`else
    localparam int TERM_LEN = 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HEX  = 2'd2,
        ST_TERM = 2'd3
    } fmt_state_e;

    function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_DIGIT_BASE + {4'd0, nib};
        end
        return ASCII_ALPHA_BASE + {4'd0, nib - 4'd10};
    endfunction

endpackage

// File: rtl/stdout_uart_if.sv
// Valid/ready/data handshake bundle, used for the upstream word port and
// the formatter-to-serialiser character path.
interface stdout_uart_if #(
    parameter int W = 8
);
    logic         val;
    logic         rdy;
    logic [W-1:0] data;

    modport master (output val, output data, input rdy);
    modport slave  (input val, input data, output rdy);
endinterface

// File: rtl/stdout_uart_tx_core.sv
// 8N1 serialiser: baud down-counter, bit index and shift register.
// char_rdy rises in the last stop-bit cycle so characters go back to back.
module uart_tx_core #(
    parameter int DIV = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       char_val,
    output logic       char_rdy,
    input  logic [7:0] char_data,
    output logic       tx_o
);
    localparam int            CW      = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    left_q, left_d;
    logic [8:0]    sh_q, sh_d;
    logic          busy_q, busy_d;
    logic          tx_q, tx_d;
    logic          last_cyc;

    assign last_cyc = busy_q && (cnt_q == '0) && (left_q == 4'd0);
    assign char_rdy = !busy_q || last_cyc;
    assign tx_o     = tx_q;

    always_comb begin
        cnt_d  = cnt_q;
        left_d = left_q;
        sh_d   = sh_q;
        busy_d = busy_q;
        tx_d   = tx_q;
        if (busy_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (left_q == 4'd0) begin
                busy_d = 1'b0;
            end else begin
                tx_d   = sh_q[0];
                sh_d   = {1'b1, sh_q[8:1]};
                left_d = left_q - 4'd1;
                cnt_d  = CNT_MAX;
            end
        end
        // Shift register holds data then stop bit; the start bit goes straight to the line.
        if (char_val && char_rdy) begin
            busy_d = 1'b1;
            tx_d   = 1'b0;
            sh_d   = {1'b1, char_data};
            left_d = 4'd9;
            cnt_d  = CNT_MAX;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            left_q <= 4'd0;
            sh_q   <= '1;
            busy_q <= 1'b0;
            tx_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            left_q <= left_d;
            sh_q   <= sh_d;
            busy_q <= busy_d;
            tx_q   <= tx_d;
        end
    end
endmodule

// File: rtl/stdout_uart.sv
// 16-bit word FIFO feeding a hex formatter and 8N1 UART; batches until half
// full unless flushing. Terminator set by STDOUT_UART_CRLF_EN (see toy_pkg).
//
// state   | meaning
// IDLE    | waiting for FIFO data and flush or half-full
// LOAD    | pop head word into the formatter
// HEX     | send four hex digits, MSB nibble first
// TERM    | send terminator, then back to IDLE
module stdout_uart
    import toy_pkg::*;
#(
    parameter int DIV   = 868,
    parameter int DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stdout_val_i,
    input  logic [15:0] stdout_data_i,
    output logic        stdout_rdy_o,
    input  logic        stdout_flush_i,
    output logic        uart_tx_o,
    output logic        busy_o
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] HALF = (AW + 1)'(DEPTH / 2);

    logic [15:0] mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d, count;
    logic        full, empty, push, pop;
    fmt_state_e  state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [1:0]  nib_q, nib_d;
    logic [0:0]  term_q, term_d;
    logic        term_last;

    stdout_uart_if #(.W(8)) ch_if ();

    assign count        = wr_q - rd_q;
    assign empty        = (wr_q == rd_q);
    assign full         = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign stdout_rdy_o = !full;
    assign push         = stdout_val_i && !full;
    assign pop          = (state_q == ST_LOAD);
    assign busy_o       = !empty || (state_q != ST_IDLE);
    assign wr_d         = wr_q + {{AW{1'b0}}, push};
    assign rd_d         = rd_q + {{AW{1'b0}}, pop};
    assign term_last    = (term_q == 1'(TERM_LEN - 1));

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        nib_d      = nib_q;
        term_d     = term_q;
        ch_if.val  = 1'b0;
        ch_if.data = ASCII_LF;
        case (state_q)
            ST_IDLE: begin
                if (!empty && (stdout_flush_i || count >= HALF)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                word_d  = mem_q[rd_q[AW-1:0]];
                nib_d   = 2'd0;
                term_d  = 1'b0;
                state_d = ST_HEX;
            end
            ST_HEX: begin
                ch_if.val  = 1'b1;
                ch_if.data = nib_to_ascii(word_q[15:12]);
                if (ch_if.rdy) begin
                    word_d = {word_q[11:0], 4'h0};
                    nib_d  = nib_q + 2'd1;
                    if (nib_q == 2'd3) state_d = ST_TERM;
                end
            end
            ST_TERM: begin
                ch_if.val  = 1'b1;
                ch_if.data = term_last ? ASCII_LF : ASCII_CR;
                if (ch_if.rdy) begin
                    if (term_last) state_d = ST_IDLE;
                    else           term_d  = term_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q[AW-1:0]] <= stdout_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= ST_IDLE;
            word_q  <= '0;
            nib_q   <= 2'd0;
            term_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            state_q <= state_d;
            word_q  <= word_d;
            nib_q   <= nib_d;
            term_q  <= term_d;
        end
    end

    uart_tx_core #(.DIV(DIV)) u_tx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .char_val  (ch_if.val),
        .char_rdy  (ch_if.rdy),
        .char_data (ch_if.data),
        .tx_o      (uart_tx_o)
    );
endmodule

// File: tb/tb_stdout_uart.sv
// Randomized self-checking bench: a line decoder rebuilds characters from
// uart_tx_o and compares them with the hex text expected for accepted words.
module tb_stdout_uart;
    localparam int DIV   = 4;
    localparam int DEPTH = 8;
`ifdef STDOUT_UART_CRLF_EN
    localparam int CPW = 6;
`else
    localparam int CPW = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic tx, busy;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   first_low = -1;
    int   last_acc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_t[$];
    string      hexdig = "0123456789ABCDEF";

    stdout_uart_if #(.W(16)) up ();

    stdout_uart #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .stdout_val_i   (up.val),
        .stdout_data_i  (up.data),
        .stdout_rdy_o   (up.rdy),
        .stdout_flush_i (flush),
        .uart_tx_o      (tx),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line decoder: samples each bit in its middle.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                rx_t.push_back(cyc);
                repeat (DIV / 2) @(negedge clk);
                b = 8'h00;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (DIV) @(negedge clk);
                check("stop_bit", {31'd0, tx}, 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    task automatic model_word(input logic [15:0] w);
        for (int n = 3; n >= 0; n--) exp_q.push_back(hexdig[w[n*4 +: 4]]);
`ifdef STDOUT_UART_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_word(input logic [15:0] w);
        int t;
        up.val  = 1'b1;
        up.data = w;
        for (t = 0; t < 5000 && !up.rdy; t++) begin
            if (first_low < 0) first_low = n_acc;
            @(negedge clk);
        end
        if (t >= 5000) check("push_timeout", 32'd1, 32'd0);
        last_acc = cyc + 1;
        n_acc++;
        model_word(w);
        @(negedge clk);
    endtask

    task automatic idle_in();
        up.val = 1'b0;
    endtask

    task automatic wait_starts(input int n);
        int t;
        for (t = 0; t < 20000 && rx_t.size() < n; t++) @(negedge clk);
        check("start_count", rx_t.size(), n);
    endtask

    task automatic drain_compare(input string tag);
        int t;
        int n;
        n = exp_q.size();
        for (t = 0; t < 20000 && rx_q.size() < n; t++) @(negedge clk);
        check({tag, "_nchars"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) check({tag, "_char"}, rx_q[i], exp_q[i]);
        repeat (2 * DIV) @(negedge clk);
        check({tag, "_extra"}, rx_q.size(), n);
        exp_q.delete();
        rx_q.delete();
        rx_t.delete();
    endtask

    task automatic quiet(input string tag, input int n);
        int lows;
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    initial begin
        logic [15:0] w;
        up.val  = 1'b0;
        up.data = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_rdy", {31'd0, up.rdy}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Single word, flushing: latency, spacing, busy release.
        flush = 1'b1;
        push_word(16'h1A2F);
        idle_in();
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_starts(1);
        check("flush_latency", rx_t[0] - last_acc, 32'd3);
        wait_starts(CPW);
        for (int i = 1; i < CPW && i < rx_t.size(); i++)
            check("frame_spacing", rx_t[i] - rx_t[i-1], 10 * DIV);
        for (int t = 0; t < 2000 && rx_q.size() < CPW; t++) @(negedge clk);
        repeat (DIV) @(negedge clk);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("tx_end", {31'd0, tx}, 32'd1);
        drain_compare("w1A2F");

        // Extremes of the digit set.
        push_word(16'h0000);
        push_word(16'hFFFF);
        idle_in();
        drain_compare("w0000_ffff");

        // Batch mode: nothing below half full, first frame at the fourth word.
        flush = 1'b0;
        for (int i = 0; i < 3; i++) push_word(16'($urandom));
        idle_in();
        quiet("batch_quiet", 100);
        check("batch_busy", {31'd0, busy}, 32'd1);
        push_word(16'($urandom));
        idle_in();
        wait_starts(1);
        check("half_latency", rx_t[0] - last_acc, 32'd3);
        flush = 1'b1;
        drain_compare("batch4");

        // Flush rising with words held starts draining on the next edge.
        flush = 1'b0;
        push_word(16'($urandom));
        push_word(16'($urandom));
        idle_in();
        quiet("held_quiet", 30);
        flush = 1'b1;
        last_acc = cyc + 1;
        wait_starts(1);
        check("flush_rise_latency", rx_t[0] - last_acc, 32'd2);
        drain_compare("flush_rise");

        // Back-to-back burst overfills the FIFO.
        first_low = -1;
        n_acc = 0;
        for (int i = 0; i < 12; i++) push_word(16'($urandom));
        idle_in();
        check("full_at_word", first_low, DEPTH + 1);
        drain_compare("burst12");

        // Reset in the middle of a data bit of the second character.
        w = 16'($urandom);
        push_word(w);
        push_word(16'($urandom));
        idle_in();
        wait_starts(2);
        for (int t = 0; t < 100 && rx_t.size() >= 2 && cyc < rx_t[1] + 2 * DIV + 1; t++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_rdy", {31'd0, up.rdy}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (12 * DIV) @(negedge clk);
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        quiet("post_rst_quiet", 300);
        check("post_rst_frames", rx_q.size(), 0);

        // Recovery after reset.
        w = 16'($urandom);
        push_word(w);
        idle_in();
        drain_compare("recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d, required finish earlier", cyc);
        $fatal(1);
    end
endmodule
